serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial unsigned subtractor with valid/ready handshakes on both sides. It is the inverse-direction companion of the team's combinational ripple-carry adder. It computes `a - b` one bit per clock, LSB first, using a single full-subtractor cell, and returns the difference plus a borrow-out flag. The design trades latency for area and is driven from the same top-level testbench harness as the adder.

## Interface
- `Width`, default 4, operand and result width in bits; legal range 1 and up.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands `a`/`b` are valid.
- `in_ready`  out  1  block can accept operands.
- `a`  in  Width  minuend, unsigned.
- `b`  in  Width  subtrahend, unsigned.
- `out_valid`  out  1  `diff`/`b_out` are valid.
- `out_ready`  in  1  consumer accepts the result.
- `diff`  out  Width  `(a - b) mod 2^Width`.
- `b_out`  out  1  borrow out; 1 iff `a < b` (unsigned).

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid & in_ready`: load `a`/`b` into shift registers, clear the borrow flop and bit counter, then go to RUN.
- **RUN**
  - Each cycle the cell takes `ai = a_sh[0]`, `bi = b_sh[0]` and borrow `bor`.
  - `d = ai ^ bi ^ bor`.
  - `bor_next = (~ai & bi) | (~(ai ^ bi) & bor)`.
  - `d` shifts into `diff_sh` from the MSB side. `a_sh`/`b_sh` shift right. Counter increments.
  - After the Width-th bit, go to DONE. Output registers `diff` and `b_out` capture the final values on that same edge.
- **DONE**
  - `out_valid`=1; `diff` and `b_out` are held stable.
  - On `out_valid & out_ready`, go to IDLE.
- `in_ready` is a pure function of state: it equals (state == IDLE). No accept-while-busy and no result bypass.
- `in_valid` is ignored in RUN and DONE; `a`/`b` may change freely there without effect.
- Counter width is `$clog2(Width+1)`. For Width=1, RUN lasts exactly one cycle.
- **Reset values** (asserted asynchronously, independent of clock):
  - state = IDLE;
  - `in_ready`=1;
  - `out_valid`=0, `diff`=0, `b_out`=0;
  - shift registers, borrow and counter = 0.
- **Reset mid-operation** (RUN or DONE): the operation is discarded and no result is produced. The first clock edge after deassertion may accept new operands.

## Timing
- Accept edge T0. RUN covers edges T1..T(Width). `out_valid` rises after edge T(Width).
- Latency from accept to result is Width cycles.
- Output hold: while `out_valid & ~out_ready`, `diff` and `b_out` do not change.
- After the output handshake at edge Tk, `in_ready`=1 from Tk onward. The next accept is possible at edge Tk+1.
- Maximum throughput is one result per Width+2 cycles.
- `diff` and `b_out` retain the last result after returning to IDLE. Consumers qualify them with `out_valid` only.

## Structure
- Package `sub_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_e`;
  - localparam for reset values.
- Sub-module `full_subtractor`: purely combinational, 1-bit.
  - Inputs: `a`, `b`, `b_in`.
  - Outputs: `d`, `b_out`.
  - Instantiated once.
- Top-level harness: instantiates `serial_subtractor` with Width=4. VCD tracing is enabled under `+trace`.

## Test plan
- Width=4, a=9, b=3, `out_ready`=1 → `out_valid` 4 cycles after accept, `diff`=6, `b_out`=0, `in_ready`=1 the following cycle.
- a=3, b=9 → `diff`=10 (0xA), `b_out`=1. Then a=0, b=15 → `diff`=1, `b_out`=1. Then a=15, b=15 → `diff`=0, `b_out`=0.
- Backpressure: a=12, b=5, `out_ready` held 0 for 6 cycles.
  - `diff`=7 and `b_out`=0 stay stable; `in_ready`=0 throughout.
  - A pulse on `in_valid` with a=1, b=1 during this time is ignored.
  - Result transfers when `out_ready`=1.
- Reset mid-RUN: `rst_n` low 2 cycles after accepting a=8, b=1.
  - Immediately: `out_valid`=0, `in_ready`=1, `diff`=0.
  - Next op a=5, b=2 gives `diff`=3, `b_out`=0.
- Exhaustive: all 256 (a, b) pairs back-to-back with random `out_ready` stalls → every `diff` equals `(a-b)&0xF` and every `b_out` equals `(a<b)`. Repeat with Width=1 (all 4 pairs).

Source files
------------

// File: rtl/sub_pkg.sv
// Shared types and reset constants for the bit-serial subtractor.
// Provides the FSM state enum and the reset values of the visible outputs.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sub_state_e;

    localparam sub_state_e RST_STATE     = IDLE;
    localparam logic       RST_IN_READY  = 1'b1;
    localparam logic       RST_OUT_VALID = 1'b0;
    localparam logic       RST_B_OUT     = 1'b0;
    localparam logic       RST_BORROW    = 1'b0;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - b_in, borrow out in b_out.
// Ports: a, b, b_in (in), d, b_out (out). Purely combinational.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic d,
    output logic b_out
);

    assign d     = a ^ b ^ b_in;
    assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Ports: clk, rst_n, in_valid/in_ready/a/b, out_valid/out_ready/diff/b_out.
module serial_subtractor #(
    parameter int Width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] diff,
    output logic             b_out
);

    import sub_pkg::*;

    localparam int CntW = $clog2(Width + 1);

    sub_state_e       state_q;
    logic [Width-1:0] a_sh_q;
    logic [Width-1:0] b_sh_q;
    logic [Width-1:0] diff_sh_q;
    logic [Width-1:0] diff_sh_d;
    logic             bor_q;
    logic             bor_d;
    logic             d_bit;
    logic [CntW-1:0]  cnt_q;
    logic [Width-1:0] diff_q;
    logic             b_out_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             last_bit;

    full_subtractor u_cell (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .b_in  (bor_q),
        .d     (d_bit),
        .b_out (bor_d)
    );

    // New difference bit enters at the MSB so that after Width shifts
    // the LSB computed first has arrived at bit 0.
    generate
        if (Width == 1) begin : g_w1
            assign diff_sh_d = d_bit;
        end else begin : g_wn
            assign diff_sh_d = {d_bit, diff_sh_q[Width-1:1]};
        end
    endgenerate

    assign last_bit = (cnt_q == CntW'(Width - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_STATE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            diff_sh_q   <= '0;
            bor_q       <= RST_BORROW;
            cnt_q       <= '0;
            diff_q      <= '0;
            b_out_q     <= RST_B_OUT;
            in_ready_q  <= RST_IN_READY;
            out_valid_q <= RST_OUT_VALID;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_sh_q     <= a;
                        b_sh_q     <= b;
                        diff_sh_q  <= '0;
                        bor_q      <= 1'b0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q    <= a_sh_q >> 1;
                    b_sh_q    <= b_sh_q >> 1;
                    diff_sh_q <= diff_sh_d;
                    bor_q     <= bor_d;
                    cnt_q     <= cnt_q + CntW'(1);
                    if (last_bit) begin
                        diff_q      <= diff_sh_d;
                        b_out_q     <= bor_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign b_out     = b_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at Width=4 and Width=1.
// Drives and samples on the falling edge; DUT updates on the rising edge.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] diff;
    logic       b_out;

    logic       in_valid1;
    logic       in_ready1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       out_valid1;
    logic       out_ready1;
    logic [0:0] diff1;
    logic       b_out1;

    int passed;
    int total;

    logic [3:0] va [4] = '{4'd9, 4'd3, 4'd0, 4'd15};
    logic [3:0] vb [4] = '{4'd3, 4'd9, 4'd15, 4'd15};
    logic [3:0] vd [4] = '{4'd6, 4'd10, 4'd1, 4'd0};
    logic       vo [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    serial_subtractor #(.Width(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .b_out     (b_out)
    );

    serial_subtractor #(.Width(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .diff      (diff1),
        .b_out     (b_out1)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        #12;
        total++;
        if ({in_ready, out_valid, b_out, diff} !== 7'b1000000)
            $display("FAIL reset_w4 got %b want 1000000",
                     {in_ready, out_valid, b_out, diff});
        else passed++;
        total++;
        if ({in_ready1, out_valid1, b_out1, diff1} !== 4'b1000)
            $display("FAIL reset_w1 got %b want 1000",
                     {in_ready1, out_valid1, b_out1, diff1});
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_one(input logic [3:0] ia, input logic [3:0] ib,
                           input logic [3:0] ed, input logic eb,
                           input string nm);
        int lat;
        in_valid  = 1'b1;
        a         = ia;
        b         = ib;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0)
            $display("FAIL %s_busy got %b want 0", nm, in_ready);
        else passed++;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat !== 4)
            $display("FAIL %s_latency got %0d want 4", nm, lat);
        else passed++;
        total++;
        if (diff !== ed || b_out !== eb)
            $display("FAIL %s_result got %0d/%b want %0d/%b",
                     nm, diff, b_out, ed, eb);
        else passed++;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL %s_return got rdy=%b vld=%b want 1/0",
                     nm, in_ready, out_valid);
        else passed++;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++)
            run_one(va[i], vb[i], vd[i], vo[i], $sformatf("basic%0d", i));
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 4'd12;
        b         = 4'd5;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (diff !== 4'd7 || b_out !== 1'b0 || lat !== 4)
            $display("FAIL bp_result got %0d/%b lat %0d want 7/0 lat 4",
                     diff, b_out, lat);
        else passed++;
        for (int k = 0; k < 6; k++) begin
            in_valid = (k == 2);
            a = (k == 2) ? 4'd1 : 4'(k);
            b = (k == 2) ? 4'd1 : 4'(15 - k);
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                diff !== 4'd7 || b_out !== 1'b0)
                $display("FAIL bp_hold%0d got v=%b r=%b d=%0d bo=%b want 1/0/7/0",
                         k, out_valid, in_ready, diff, b_out);
            else passed++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== 4'd7)
            $display("FAIL bp_release got v=%b r=%b d=%0d want 0/1/7",
                     out_valid, in_ready, diff);
        else passed++;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL bp_ignored got r=%b v=%b want 1/0",
                     in_ready, out_valid);
        else passed++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 4'd8;
        b         = 4'd1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== 4'd0)
            $display("FAIL rst_mid got v=%b r=%b d=%0d want 0/1/0",
                     out_valid, in_ready, diff);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        run_one(4'd5, 4'd2, 4'd3, 1'b0, "after_rst");
    endtask

    task automatic test_exhaustive();
        int lat;
        int n;
        logic [3:0] ed;
        logic eb;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                ed = 4'(ia - ib);
                eb = (ia < ib);
                in_valid  = 1'b1;
                a         = 4'(ia);
                b         = 4'(ib);
                out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                in_valid = 1'b0;
                lat = 0;
                while (!out_valid && lat < 20) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    lat++;
                end
                total++;
                if (lat !== 4 || diff !== ed || b_out !== eb)
                    $display("FAIL ex %0d-%0d got %0d/%b lat %0d want %0d/%b lat 4",
                             ia, ib, diff, b_out, lat, ed, eb);
                else passed++;
                n = 0;
                do begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    n++;
                    if (out_valid) begin
                        total++;
                        if (diff !== ed || b_out !== eb)
                            $display("FAIL ex_hold %0d-%0d got %0d/%b want %0d/%b",
                                     ia, ib, diff, b_out, ed, eb);
                        else passed++;
                    end
                end while (out_valid && n < 50);
                total++;
                if (out_valid !== 1'b0 || in_ready !== 1'b1)
                    $display("FAIL ex_drain %0d-%0d got v=%b r=%b want 0/1",
                             ia, ib, out_valid, in_ready);
                else passed++;
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_exhaustive_w1();
        int lat;
        int n;
        logic ed;
        logic eb;
        for (int ia = 0; ia < 2; ia++) begin
            for (int ib = 0; ib < 2; ib++) begin
                ed = 1'(ia ^ ib);
                eb = (ia < ib);
                in_valid1  = 1'b1;
                a1         = 1'(ia);
                b1         = 1'(ib);
                out_ready1 = 1'b0;
                @(negedge clk);
                in_valid1 = 1'b0;
                lat = 0;
                while (!out_valid1 && lat < 20) begin
                    @(negedge clk);
                    lat++;
                end
                total++;
                if (lat !== 1 || diff1 !== ed || b_out1 !== eb)
                    $display("FAIL w1 %0d-%0d got %b/%b lat %0d want %b/%b lat 1",
                             ia, ib, diff1, b_out1, lat, ed, eb);
                else passed++;
                n = 0;
                do begin
                    out_ready1 = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    n++;
                end while (out_valid1 && n < 50);
                total++;
                if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1)
                    $display("FAIL w1_drain %0d-%0d got v=%b r=%b want 0/1",
                             ia, ib, out_valid1, in_ready1);
                else passed++;
            end
        end
    endtask

    initial begin
        clk        = 1'b0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        out_ready  = 1'b1;
        in_valid1  = 1'b0;
        a1         = '0;
        b1         = '0;
        out_ready1 = 1'b1;
        passed     = 0;
        total      = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid();
        test_exhaustive();
        test_exhaustive_w1();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
